fb_pixel_source: RTL

FB_PIXEL_SOURCE -- requirements
Module: fb_pixel_source

---
 rtl/fb_pixel_source.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/fb_pixel_source.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fb_pixel_source                                              |
// | Description : Cell framebuffer (FB_W x FB_H, 8-bit RGB332) feeding a VGA   |
// |               timing stage. Each cell covers 2**SCALE_LOG2 square screen   |
// |               pixels. Colour for a sampled (next_x,next_y) appears on      |
// |               red/green/blue two cycles after sampling. Optional clear     |
// |               engine fills the whole buffer with one colour.               |
// | Option      : define FB_PIXEL_SOURCE_CLEAR_EN to build the clear engine.   |
// | Ports       : CLOCK_50 (clk), reset (sync, active-low),                    |
// |               next_x/next_y  : requested screen coordinate                 |
// |               red/green/blue : registered expanded pixel colour            |
// |               wr_valid/wr_ready, wr_x/wr_y/wr_color : host cell write      |
// |               clr_req/clr_color/busy : clear request, fill colour, busy    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fb_pixel_source #(
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int SCALE_LOG2 = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [9:0] next_x,
  input  logic [9:0] next_y,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_x,
  input  logic [6:0] wr_y,
  input  logic [7:0] wr_color,
  input  logic       clr_req,
  input  logic [7:0] clr_color,
  output logic       busy
);

  localparam int          DEPTH     = FB_W * FB_H;
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [10:0] SCR_W     = 11'(FB_W << SCALE_LOG2);
  localparam logic [10:0] SCR_H     = 11'(FB_H << SCALE_LOG2);
  localparam logic [8:0]  CELLS_X   = 9'(FB_W);
  localparam logic [7:0]  CELLS_Y   = 8'(FB_H);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  // ---------------------------------------------------------------- read side
  logic [9:0]    cell_x;
  logic [9:0]    cell_y;
  logic          in_range;
  logic [AW-1:0] pix_addr;

  always_comb begin
    cell_x   = next_x >> SCALE_LOG2;
    cell_y   = next_y >> SCALE_LOG2;
    // Unsigned compare: wrapped negative offsets land far above the limit.
    in_range = ({1'b0, next_x} < SCR_W) && ({1'b0, next_y} < SCR_H);
    // Out-of-range coordinates would index past the RAM; park them on 0.
    pix_addr = in_range ? (AW'(cell_y) * AW'(FB_W) + AW'(cell_x)) : '0;
  end

  logic [AW-1:0] addr_s0;
  logic          in_s0;
  logic          in_s1;
  logic [7:0]    rd_data;

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      addr_s0 <= '0;
      in_s0   <= 1'b0;
      in_s1   <= 1'b0;
      red     <= 8'h00;
      green   <= 8'h00;
      blue    <= 8'h00;
    end else begin
      addr_s0 <= pix_addr;
      in_s0   <= in_range;
      in_s1   <= in_s0;
      if (in_s1) begin
        red   <= {rd_data[7:5], rd_data[7:5], rd_data[7:6]};
        green <= {rd_data[4:2], rd_data[4:2], rd_data[4:3]};
        blue  <= {4{rd_data[1:0]}};
      end else begin
        red   <= 8'h00;
        green <= 8'h00;
        blue  <= 8'h00;
      end
    end
  end

  // --------------------------------------------------------------- write side
  logic          host_ok;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic [7:0]    clr_col;

  always_comb begin
    host_ok   = ({1'b0, wr_x} < CELLS_X) && ({1'b0, wr_y} < CELLS_Y);
    host_addr = AW'(wr_y) * AW'(FB_W) + AW'(wr_x);
    // Out-of-bounds writes still complete the handshake but are dropped.
    host_we   = wr_valid && wr_ready && host_ok;
  end

`ifdef FB_PIXEL_SOURCE_CLEAR_EN
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0] state;
  logic [0:0] state_nxt;

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state    <= ST_IDLE;
      clr_addr <= '0;
      clr_col  <= 8'h00;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE) begin
        if (clr_req) begin
          clr_addr <= '0;
          clr_col  <= clr_color;
        end
      end else begin
        clr_addr <= clr_addr + AW'(1);
      end
    end
  end

  // Requests arriving during CLEAR are dropped, not queued.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (clr_req) state_nxt = ST_CLEAR;
      ST_CLEAR: if (clr_addr == LAST_ADDR) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Reset gates both write sources so an aborted clear leaves the cell under
  // the reset edge untouched.
  always_comb begin
    busy     = (state == ST_CLEAR);
    wr_ready = reset && (state == ST_IDLE);
    clr_we   = reset && (state == ST_CLEAR);
  end
`else
  logic unused_clr;
  assign unused_clr = ^{clr_req, clr_color};
  assign busy       = 1'b0;
  assign wr_ready   = reset;
  assign clr_we     = 1'b0;
  assign clr_addr   = '0;
  assign clr_col    = 8'h00;
`endif

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [7:0]    ram_wdata;

  always_comb begin
    ram_we    = host_we || clr_we;
    ram_waddr = clr_we ? clr_addr : host_addr;
    ram_wdata = clr_we ? clr_col  : wr_color;
  end

  // Contents are never reset. Same-address read/write returns the old data.
  logic [7:0] mem [DEPTH];

  always_ff @(posedge CLOCK_50) begin
    if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
    rd_data <= mem[addr_s0];
  end

endmodule
`default_nettype wire
